// File: rtl/intr_ctrl_if.sv
// Bus between the CPU pipeline and the interrupt controller.
// The master (CPU side) drives events, mask writes and handshakes.
// The slave (controller) returns the request, cause and status.
interface intr_ctrl_if #(
  parameter int unsigned N_SRC = 4
);
  localparam int unsigned CW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] src;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             ack;
  logic             iret;
  logic             irr;
  logic [CW-1:0]    cause;
  logic             busy;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;

  modport master (
    output src, mask_we, mask_wdata, ack, iret,
    input  irr, cause, busy, pending, mask
  );

  modport slave (
    input  src, mask_we, mask_wdata, ack, iret,
    output irr, cause, busy, pending, mask
  );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches rising edges on the source lines, masks them,
// picks one by fixed priority (bit 0 highest) and runs a single non-nesting
// request -> service -> return handshake with the CPU.
module intr_ctrl #(
  parameter int unsigned N_SRC = 4
) (
  input  logic        clk,
  input  logic        reset,
  intr_ctrl_if.slave  bus
);
  localparam int unsigned CW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e           state_q, state_d;
  logic             irr_q, irr_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    cause_q, cause_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] clr;
  logic [CW-1:0]    winner;
  logic             any_cand;

  assign edges    = bus.src & ~src_q;
  assign cand     = pending_q & mask_q;
  assign any_cand = |cand;

  // Fixed-priority pick: scanning downwards leaves the lowest set index.
  always_comb begin
    winner = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (cand[i]) winner = CW'(i);
    end
  end

  // Next state, frozen cause and the pending-clear vector for an accepted ack.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    clr     = '0;
    unique case (state_q)
      StIdle: begin
        if (any_cand) begin
          cause_d = winner;
          state_d = StReq;
        end
      end
      StReq: begin
        // Ack beats a withdrawal caused by a mask write in the same cycle.
        if (bus.ack) begin
          state_d      = StService;
          clr[cause_q] = 1'b1;
        end else if (!mask_q[cause_q]) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (bus.iret) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    irr_d = (state_d == StReq);
    busy_d = (state_d == StService);
  end

  // A new edge on the bit being acknowledged survives the clear.
  always_comb begin
    pending_d = (pending_q & ~clr) | edges;
    mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
  end

  // State and status registers; src_q resets low so a line held high through
  // reset release produces exactly one event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      irr_q     <= 1'b0;
      busy_q    <= 1'b0;
      cause_q   <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      src_q     <= '0;
    end else begin
      state_q   <= state_d;
      irr_q     <= irr_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      src_q     <= bus.src;
    end
  end

  assign bus.irr     = irr_q;
  assign bus.busy    = busy_q;
  assign bus.cause   = cause_q;
  assign bus.pending = pending_q;
  assign bus.mask    = mask_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios against fixed expectations, then a
// randomized run against a behavioural model of the controller.
module tb_intr_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  intr_ctrl_if #(.N_SRC(4)) bus ();

  intr_ctrl #(.N_SRC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what the CPU should see, kept as plain flags and bits.
  logic [3:0] m_pending;
  logic [3:0] m_mask;
  logic [3:0] m_prev_src;
  bit         m_requesting;
  bit         m_in_service;
  logic [1:0] m_cause;

  // One clock: drive inputs, take the edge, advance the model, settle.
  task automatic cycle(input logic [3:0] s, input logic mwe, input logic [3:0] mwd,
                       input logic a, input logic ir, input logic rst);
    logic [3:0] nxt_pending;
    bit         found;
    bus.src        = s;
    bus.mask_we    = mwe;
    bus.mask_wdata = mwd;
    bus.ack        = a;
    bus.iret       = ir;
    reset          = rst;
    @(posedge clk);
    if (rst) begin
      m_pending    = '0;
      m_mask       = '0;
      m_prev_src   = '0;
      m_requesting = 0;
      m_in_service = 0;
      m_cause      = '0;
    end else begin
      nxt_pending = m_pending;
      if (m_requesting) begin
        if (a) begin
          m_requesting = 0;
          m_in_service = 1;
          nxt_pending[m_cause] = 1'b0;
        end else if (!m_mask[m_cause]) begin
          m_requesting = 0;
        end
      end else if (m_in_service) begin
        if (ir) m_in_service = 0;
      end else begin
        found = 0;
        for (int i = 0; i < 4; i++) begin
          if (!found && m_pending[i] && m_mask[i]) begin
            found        = 1;
            m_cause      = 2'(i);
            m_requesting = 1;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (s[i] && !m_prev_src[i]) nxt_pending[i] = 1'b1;
      end
      m_pending  = nxt_pending;
      if (mwe) m_mask = mwd;
      m_prev_src = s;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(4'b0000, 0, 4'b0000, 0, 0, 1);
    cycle(4'b0000, 0, 4'b0000, 0, 0, 1);
    checks++; if (bus.irr !== 1'b0) begin failures++; $display("FAIL reset_irr: got %b want 0", bus.irr); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.cause !== 2'd0) begin failures++; $display("FAIL reset_cause: got %0d want 0", bus.cause); end
    checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL reset_pending: got %b want 0000", bus.pending); end
    checks++; if (bus.mask !== 4'b0000) begin failures++; $display("FAIL reset_mask: got %b want 0000", bus.mask); end
    cycle(4'b0000, 0, 4'b0000, 0, 0, 0);
  endtask

  task automatic test_basic();
    cycle(4'b0000, 1, 4'b0010, 0, 0, 0);
    cycle(4'b0010, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.pending !== 4'b0010) begin failures++; $display("FAIL basic_pending: got %b want 0010", bus.pending); end
    checks++; if (bus.irr !== 1'b0) begin failures++; $display("FAIL basic_irr_early: got %b want 0", bus.irr); end
    cycle(4'b0010, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.irr !== 1'b1 || bus.cause !== 2'd1) begin failures++; $display("FAIL basic_req: got irr=%b cause=%0d want irr=1 cause=1", bus.irr, bus.cause); end
    cycle(4'b0010, 0, 4'b0000, 1, 0, 0);
    checks++; if (bus.irr !== 1'b0 || bus.busy !== 1'b1 || bus.pending !== 4'b0000) begin failures++; $display("FAIL basic_ack: got irr=%b busy=%b pending=%b want 0 1 0000", bus.irr, bus.busy, bus.pending); end
    cycle(4'b0000, 0, 4'b0000, 0, 1, 0);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_iret: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_priority();
    cycle(4'b0000, 1, 4'b1111, 0, 0, 0);
    cycle(4'b1010, 0, 4'b0000, 0, 0, 0);
    cycle(4'b1010, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.irr !== 1'b1 || bus.cause !== 2'd1) begin failures++; $display("FAIL prio_first: got irr=%b cause=%0d want irr=1 cause=1", bus.irr, bus.cause); end
    cycle(4'b1010, 0, 4'b0000, 1, 0, 0);
    checks++; if (bus.pending !== 4'b1000) begin failures++; $display("FAIL prio_pending: got %b want 1000", bus.pending); end
    cycle(4'b1010, 0, 4'b0000, 0, 1, 0);
    checks++; if (bus.irr !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL prio_gap: got irr=%b busy=%b want 0 0", bus.irr, bus.busy); end
    cycle(4'b1010, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.irr !== 1'b1 || bus.cause !== 2'd3) begin failures++; $display("FAIL prio_second: got irr=%b cause=%0d want irr=1 cause=3", bus.irr, bus.cause); end
    cycle(4'b1010, 0, 4'b0000, 1, 0, 0);
    cycle(4'b0000, 0, 4'b0000, 0, 1, 0);
  endtask

  task automatic test_masked_pending();
    cycle(4'b0000, 1, 4'b0000, 0, 0, 0);
    cycle(4'b0100, 0, 4'b0000, 0, 0, 0);
    cycle(4'b0100, 0, 4'b0000, 0, 0, 0);
    cycle(4'b0100, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.irr !== 1'b0 || bus.pending !== 4'b0100) begin failures++; $display("FAIL masked_hold: got irr=%b pending=%b want 0 0100", bus.irr, bus.pending); end
    cycle(4'b0100, 1, 4'b0100, 0, 0, 0);
    checks++; if (bus.irr !== 1'b0 || bus.mask !== 4'b0100) begin failures++; $display("FAIL unmask_edge: got irr=%b mask=%b want 0 0100", bus.irr, bus.mask); end
    cycle(4'b0100, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.irr !== 1'b1 || bus.cause !== 2'd2) begin failures++; $display("FAIL unmask_req: got irr=%b cause=%0d want irr=1 cause=2", bus.irr, bus.cause); end
    cycle(4'b0100, 0, 4'b0000, 1, 0, 0);
    cycle(4'b0000, 0, 4'b0000, 0, 1, 0);
  endtask

  task automatic test_withdraw();
    cycle(4'b0000, 1, 4'b0001, 0, 0, 0);
    cycle(4'b0001, 0, 4'b0000, 0, 0, 0);
    cycle(4'b0001, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.irr !== 1'b1 || bus.cause !== 2'd0) begin failures++; $display("FAIL wd_req: got irr=%b cause=%0d want irr=1 cause=0", bus.irr, bus.cause); end
    cycle(4'b0001, 1, 4'b0000, 0, 0, 0);
    checks++; if (bus.irr !== 1'b1) begin failures++; $display("FAIL wd_write_edge: got irr=%b want 1", bus.irr); end
    cycle(4'b0001, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.irr !== 1'b0 || bus.busy !== 1'b0 || bus.pending !== 4'b0001) begin failures++; $display("FAIL wd_withdrawn: got irr=%b busy=%b pending=%b want 0 0 0001", bus.irr, bus.busy, bus.pending); end
    cycle(4'b0001, 1, 4'b0001, 0, 0, 0);
    cycle(4'b0001, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.irr !== 1'b1) begin failures++; $display("FAIL wd_rereq: got irr=%b want 1", bus.irr); end
    cycle(4'b0001, 1, 4'b0000, 1, 0, 0);
    checks++; if (bus.busy !== 1'b1 || bus.irr !== 1'b0 || bus.pending !== 4'b0000) begin failures++; $display("FAIL wd_ack_wins: got busy=%b irr=%b pending=%b want 1 0 0000", bus.busy, bus.irr, bus.pending); end
    cycle(4'b0000, 0, 4'b0000, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    cycle(4'b0000, 1, 4'b0001, 0, 0, 0);
    cycle(4'b0001, 0, 4'b0000, 0, 0, 0);
    cycle(4'b0001, 0, 4'b0000, 0, 0, 0);
    cycle(4'b0001, 0, 4'b0000, 1, 0, 0);
    cycle(4'b0000, 0, 4'b0000, 0, 0, 0);
    cycle(4'b0001, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.busy !== 1'b1 || bus.pending !== 4'b0001) begin failures++; $display("FAIL b2b_latch: got busy=%b pending=%b want 1 0001", bus.busy, bus.pending); end
    cycle(4'b0001, 0, 4'b0000, 1, 0, 0);
    checks++; if (bus.busy !== 1'b1 || bus.irr !== 1'b0 || bus.pending !== 4'b0001) begin failures++; $display("FAIL b2b_stray_ack: got busy=%b irr=%b pending=%b want 1 0 0001", bus.busy, bus.irr, bus.pending); end
    cycle(4'b0001, 0, 4'b0000, 0, 1, 0);
    checks++; if (bus.busy !== 1'b0 || bus.irr !== 1'b0) begin failures++; $display("FAIL b2b_iret: got busy=%b irr=%b want 0 0", bus.busy, bus.irr); end
    cycle(4'b0001, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.irr !== 1'b1 || bus.cause !== 2'd0) begin failures++; $display("FAIL b2b_rereq: got irr=%b cause=%0d want irr=1 cause=0", bus.irr, bus.cause); end
    cycle(4'b0001, 0, 4'b0000, 1, 0, 0);
    cycle(4'b0001, 0, 4'b0000, 0, 1, 0);
    cycle(4'b0001, 0, 4'b0000, 0, 1, 0);
    checks++; if (bus.irr !== 1'b0 || bus.busy !== 1'b0 || bus.pending !== 4'b0000) begin failures++; $display("FAIL b2b_idle_iret: got irr=%b busy=%b pending=%b want 0 0 0000", bus.irr, bus.busy, bus.pending); end
  endtask

  task automatic test_reset_mid();
    cycle(4'b0000, 1, 4'b1111, 0, 0, 0);
    cycle(4'b0111, 0, 4'b0000, 0, 0, 0);
    cycle(4'b0111, 0, 4'b0000, 0, 0, 0);
    cycle(4'b0111, 0, 4'b0000, 1, 0, 0);
    checks++; if (bus.busy !== 1'b1 || bus.pending !== 4'b0110) begin failures++; $display("FAIL rst_setup: got busy=%b pending=%b want 1 0110", bus.busy, bus.pending); end
    cycle(4'b0110, 0, 4'b0000, 0, 0, 1);
    checks++; if ({bus.irr, bus.busy, bus.cause, bus.pending, bus.mask} !== 12'd0) begin failures++; $display("FAIL rst_mid: got irr=%b busy=%b cause=%0d pending=%b mask=%b want all 0", bus.irr, bus.busy, bus.cause, bus.pending, bus.mask); end
    cycle(4'b0010, 0, 4'b0000, 0, 0, 1);
    cycle(4'b0010, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.pending !== 4'b0010) begin failures++; $display("FAIL rst_held_event: got %b want 0010", bus.pending); end
    for (int k = 0; k < 3; k++) cycle(4'b0010, 0, 4'b0000, 0, 0, 0);
    cycle(4'b0010, 1, 4'b0010, 0, 0, 0);
    cycle(4'b0010, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.irr !== 1'b1 || bus.cause !== 2'd1) begin failures++; $display("FAIL rst_held_req: got irr=%b cause=%0d want irr=1 cause=1", bus.irr, bus.cause); end
    cycle(4'b0010, 0, 4'b0000, 1, 0, 0);
    cycle(4'b0010, 0, 4'b0000, 0, 1, 0);
    cycle(4'b0010, 0, 4'b0000, 0, 0, 0);
    cycle(4'b0010, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.pending !== 4'b0000 || bus.irr !== 1'b0) begin failures++; $display("FAIL rst_single_event: got pending=%b irr=%b want 0000 0", bus.pending, bus.irr); end
  endtask

  task automatic test_random();
    logic [3:0] s;
    s = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(3, 0) == 0) s[i] = ~s[i];
      end
      cycle(s, ($urandom_range(7, 0) == 0), 4'($urandom), ($urandom_range(2, 0) == 0),
            ($urandom_range(2, 0) == 0), ($urandom_range(149, 0) == 0));
      checks++;
      if (bus.irr !== m_requesting || bus.busy !== m_in_service || bus.cause !== m_cause ||
          bus.pending !== m_pending || bus.mask !== m_mask) begin
        failures++;
        $display("FAIL rand_cycle_%0d: got irr=%b busy=%b cause=%0d pending=%b mask=%b want irr=%b busy=%b cause=%0d pending=%b mask=%b",
                 n, bus.irr, bus.busy, bus.cause, bus.pending, bus.mask,
                 m_requesting, m_in_service, m_cause, m_pending, m_mask);
      end
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    bus.src        = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.ack        = 1'b0;
    bus.iret       = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_masked_pending();
    test_withdraw();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
